// File: rtl/tbuart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive monitor.
package uart_rx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);
  localparam logic [7:0]  ASCII_LF  = 8'h0A;

endpackage

// File: rtl/tbuart_rx_if.sv
// Serial input and decoded-byte outputs of the UART receive monitor.
interface tbuart_rx_if #(
  parameter int unsigned CNT_W = 16
);
  import uart_rx_pkg::*;

  logic                 ser_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 line_done;
  logic                 busy;
  logic [CNT_W-1:0]     byte_count;

  modport master (
    output ser_rx,
    input  rx_data, rx_valid, frame_err, line_done, busy, byte_count
  );

  modport slave (
    input  ser_rx,
    output rx_data, rx_valid, frame_err, line_done, busy, byte_count
  );

endinterface

// File: rtl/tbuart_rx_sync2.sv
// Two-flop synchronizer; resets to the idle-high line level.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tbuart_rx.sv
// 8N1 UART receive monitor: decodes bytes, flags framing errors,
// counts good bytes and marks line-feed characters.
module tbuart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 16
) (
  input logic         clock,
  input logic         reset,
  tbuart_rx_if.slave  bus
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 rx_s;
  logic                 tick;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 ld_nxt;

  sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.ser_rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tick marks the cycle on which the current state samples rx_s
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (timer == HALF_LAST) begin
               tick      = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
             end
      DATA:  if (timer == BIT_LAST) begin
               tick = 1'b1;
               if (idx == IDX_LAST) state_nxt = STOP;
             end
      STOP:  if (timer == BIT_LAST) begin
               tick      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    ld_nxt    = 1'b0;
    if (state == STOP && tick) begin
      if (rx_s) begin
        valid_nxt = 1'b1;
        ld_nxt    = (shift == ASCII_LF);
      end else begin
        ferr_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer          <= '0;
      idx            <= '0;
      shift          <= '0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.line_done  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.byte_count <= '0;
    end else begin
      timer         <= (state == IDLE || tick) ? '0 : timer + TMR_W'(1);
      bus.rx_valid  <= valid_nxt;
      bus.frame_err <= ferr_nxt;
      bus.line_done <= ld_nxt;
      bus.busy      <= (state_nxt != IDLE);
      if (state == START) idx <= '0;
      if (state == DATA && tick) begin
        shift[idx] <= rx_s;
        idx        <= idx + IDX_W'(1);
      end
      if (valid_nxt) begin
        bus.rx_data <= shift;
        if (bus.byte_count != '1) bus.byte_count <= bus.byte_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tbuart_rx.sv
// Directed bench for tbuart_rx at 16 clocks per bit.
module tb_tbuart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tbuart_rx_if #(.CNT_W(CNT_W)) bus ();

  tbuart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   valid_cyc = 0;
  int   valid_cnt = 0;
  int   ferr_cnt = 0;
  int   ld_cnt = 0;
  int   overlap = 0;
  logic [7:0] dq[$];
  logic       ldq[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.rx_valid) begin
      valid_cnt++;
      dq.push_back(bus.rx_data);
      ldq.push_back(bus.line_done);
      valid_cyc = cyc;
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.line_done) ld_cnt++;
    if (bus.rx_valid && bus.frame_err) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b, input int len);
    bus.ser_rx = b;
    tick_n(len);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int stop_len);
    start_cyc = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop, stop_len);
  endtask

  initial begin
    logic saw_busy;
    int   lat;
    logic [7:0] part;

    bus.ser_rx = 1'b1;
    tick_n(3);
    check("rst_rx_data",   32'(bus.rx_data), 32'h0);
    check("rst_rx_valid",  32'(bus.rx_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_line_done", 32'(bus.line_done), 32'h0);
    check("rst_busy",      32'(bus.busy), 32'h0);
    check("rst_count",     32'(bus.byte_count), 32'h0);
    reset = 1'b0;
    tick_n(4);

    // single byte 0x55 with latency measurement
    send_byte(8'h55, 1'b1, CPB);
    lat = valid_cyc - start_cyc;
    tick_n(4);
    check("b55_valid_cnt", 32'(valid_cnt), 32'd1);
    check("b55_data",      32'(dq[0]), 32'h55);
    check("b55_count",     32'(bus.byte_count), 32'd1);
    check("b55_ferr",      32'(ferr_cnt), 32'd0);
    check("b55_latency",   32'(lat >= 154 && lat <= 156), 32'd1);
    check("b55_busy_idle", 32'(bus.busy), 32'h0);

    // 0xA5 with a short stop bit, immediately followed by 0x0A
    send_byte(8'hA5, 1'b1, HALF + 4);
    send_byte(8'h0A, 1'b1, CPB);
    tick_n(4);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
    check("b2b_data0",     32'(dq[1]), 32'hA5);
    check("b2b_data1",     32'(dq[2]), 32'h0A);
    check("b2b_ld0",       32'(ldq[1]), 32'h0);
    check("b2b_ld1",       32'(ldq[2]), 32'h1);
    check("b2b_ld_cnt",    32'(ld_cnt), 32'd1);
    check("b2b_count",     32'(bus.byte_count), 32'd3);

    // 3-cycle glitch on the idle line
    bus.ser_rx = 1'b0;
    tick_n(3);
    bus.ser_rx = 1'b1;
    saw_busy = bus.busy;
    for (int i = 0; i < int'(HALF) + 3; i++) begin
      tick_n(1);
      if (bus.busy) saw_busy = 1'b1;
    end
    check("glitch_saw_busy", 32'(saw_busy), 32'h1);
    check("glitch_busy_end", 32'(bus.busy), 32'h0);
    tick_n(CPB);
    check("glitch_valid",    32'(valid_cnt), 32'd3);
    check("glitch_ferr",     32'(ferr_cnt), 32'd0);

    // 0x3C with a low stop bit, then a good 0x41
    send_byte(8'h3C, 1'b0, CPB);
    bus.ser_rx = 1'b1;
    tick_n(2 * CPB);
    check("ferr_cnt",       32'(ferr_cnt), 32'd1);
    check("ferr_valid_cnt", 32'(valid_cnt), 32'd3);
    check("ferr_data_kept", 32'(bus.rx_data), 32'h0A);
    check("ferr_count",     32'(bus.byte_count), 32'd3);
    send_byte(8'h41, 1'b1, CPB);
    tick_n(4);
    check("b41_valid_cnt", 32'(valid_cnt), 32'd4);
    check("b41_data",      32'(dq[3]), 32'h41);
    check("b41_count",     32'(bus.byte_count), 32'd4);

    // reset in the middle of data bit 4
    part = 8'h81;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(part[i], CPB);
    drive_bit(part[4], HALF);
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    bus.ser_rx = 1'b1;
    tick_n(1);
    check("mid_rst_data",  32'(bus.rx_data), 32'h0);
    check("mid_rst_count", 32'(bus.byte_count), 32'h0);
    check("mid_rst_busy",  32'(bus.busy), 32'h0);
    check("mid_rst_valid", 32'(bus.rx_valid), 32'h0);
    check("mid_rst_ferr",  32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    tick_n(3 * CPB);
    check("mid_no_valid", 32'(valid_cnt), 32'd4);
    check("mid_no_ferr",  32'(ferr_cnt), 32'd1);
    send_byte(8'h7E, 1'b1, CPB);
    tick_n(4);
    check("b7e_data",  32'(dq[4]), 32'h7E);
    check("b7e_out",   32'(bus.rx_data), 32'h7E);
    check("b7e_count", 32'(bus.byte_count), 32'd1);

    // "B9\n" stream
    send_byte(8'h42, 1'b1, CPB);
    send_byte(8'h39, 1'b1, CPB);
    send_byte(8'h0A, 1'b1, CPB);
    tick_n(4);
    check("str_data0",  32'(dq[5]), 32'h42);
    check("str_data1",  32'(dq[6]), 32'h39);
    check("str_data2",  32'(dq[7]), 32'h0A);
    check("str_ld_B",   32'(ldq[5]), 32'h0);
    check("str_ld_nl",  32'(ldq[7]), 32'h1);
    check("str_ld_cnt", 32'(ld_cnt), 32'd2);
    check("str_count",  32'(bus.byte_count), 32'd4);
    check("str_ferr",   32'(ferr_cnt), 32'd1);
    check("overlap",    32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
